// File: rtl/dmem_ctrl_if.sv
// Pipeline-side and memory-side signals of the data-memory controller.
// master = pipeline plus memory model, slave = dmem_ctrl.
interface dmem_ctrl_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] read_data;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        misaligned;
  logic        timeout_err;

  modport master (
    output req_read, req_write, addr, wdata, size, sign_ext, mem_ack, mem_rdata,
    input  read_data, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           misaligned, timeout_err
  );

  modport slave (
    input  req_read, req_write, addr, wdata, size, sign_ext, mem_ack, mem_rdata,
    output read_data, stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           misaligned, timeout_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the MEM stage: lane steering, load
// extension, misalignment rejection and a bounded wait for the memory ack.
module dmem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counter value in the last WAIT cycle allowed before the access is aborted.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] cnt_reg;

  logic          req_valid;
  logic          req_bad;
  logic          accept;
  logic          reject;
  logic          stall_c;

  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;

  logic [1:0]    lane_reg;
  logic [1:0]    size_reg;
  logic          sign_reg;
  logic          load_reg;
  logic [31:0]   rdata_shift;
  logic [31:0]   load_val;

  logic          mem_req_reg;
  logic          mem_we_reg;
  logic [31:0]   mem_addr_reg;
  logic [3:0]    mem_be_reg;
  logic [31:0]   mem_wdata_reg;
  logic [31:0]   read_data_reg;
  logic          misaligned_reg;
  logic          timeout_err_reg;

  assign req_valid = bus.req_read | bus.req_write;
  assign req_bad   = (bus.size == 2'b11)
                   | ((bus.size == 2'b01) & bus.addr[0])
                   | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));
  assign accept    = (state_reg == IDLE) & req_valid & ~req_bad;
  assign reject    = (state_reg == IDLE) & req_valid & req_bad;

  // Per-lane enable and write data; illegal sizes never reach the registers.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign be_calc[gi] = (bus.size == 2'b00) ? (bus.addr[1:0] == LANE) :
                         (bus.size == 2'b01) ? (bus.addr[1] == LANE[1]) : 1'b1;
    assign wdata_calc[8*gi +: 8] = (bus.size == 2'b00) ? bus.wdata[7:0] :
                                   (bus.size == 2'b01) ? bus.wdata[8*(gi%2) +: 8] :
                                                         bus.wdata[8*gi +: 8];
  end

  assign rdata_shift = bus.mem_rdata >> {lane_reg, 3'b000};

  always_comb begin
    load_val = rdata_shift;
    case (size_reg)
      2'b00:   load_val = {{24{sign_reg & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_val = {{16{sign_reg & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_val = rdata_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; an ack in the final WAIT cycle wins over the abort.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack || (cnt_reg == LAST)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: stall is raised in the accept cycle itself and held in WAIT.
  always_comb begin
    stall_c = 1'b0;
    case (state_reg)
      IDLE:    stall_c = accept;
      WAIT:    stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg         <= '0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_be_reg      <= '0;
      mem_wdata_reg   <= '0;
      read_data_reg   <= '0;
      misaligned_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      lane_reg        <= '0;
      size_reg        <= '0;
      sign_reg        <= 1'b0;
      load_reg        <= 1'b0;
    end else begin
      misaligned_reg <= reject;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= bus.req_write;
            mem_addr_reg  <= {bus.addr[31:2], 2'b00};
            mem_be_reg    <= be_calc;
            mem_wdata_reg <= wdata_calc;
            lane_reg      <= bus.addr[1:0];
            size_reg      <= bus.size;
            sign_reg      <= bus.sign_ext;
            load_reg      <= ~bus.req_write;
            cnt_reg       <= '0;
          end else if (reject) begin
            read_data_reg <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            mem_req_reg <= 1'b0;
            if (load_reg) begin
              read_data_reg <= load_val;
            end
          end else if (cnt_reg == LAST) begin
            mem_req_reg     <= 1'b0;
            timeout_err_reg <= 1'b1;
            read_data_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall       = stall_c;
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_be      = mem_be_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.read_data   = read_data_reg;
  assign bus.misaligned  = misaligned_reg;
  assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized and directed bench for dmem_ctrl against an arithmetic model
// of lane steering, extension, misalignment and timeout behaviour.
module tb_dmem_ctrl;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [31:0] exp_rd;
  logic        exp_to;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a & 32'd3);
    return (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a & 32'd3);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic sx, input logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(a & 32'd3);
    v = rd >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.size      = '0;
    bus.sign_ext  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_read_data"}, bus.read_data, 32'h0);
    check_val({tag, "_stall"}, 32'(bus.stall), 32'h0);
    check_val({tag, "_mem_req"}, 32'(bus.mem_req), 32'h0);
    check_val({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
    check_val({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    check_val({tag, "_mem_be"}, 32'(bus.mem_be), 32'h0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    check_val({tag, "_misaligned"}, 32'(bus.misaligned), 32'h0);
    check_val({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'h0);
  endtask

  // ack_k: WAIT cycle (1..T) carrying mem_ack; anything else means no ack.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                         input int ack_k, input logic [31:0] rdat, input logic poke_done);
    logic        bad;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        acked;
    int          cycles;
    bad    = model_bad(sz, a);
    e_addr = a & 32'hFFFF_FFFC;
    e_be   = model_be(sz, a);
    e_wd   = model_wd(sz, wd);
    acked  = 1'b0;
    cycles = 0;
    n_txn++;

    @(negedge clk);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.size      = sz;
    bus.sign_ext  = sx;
    #1 check_val("stall_req_cycle", 32'(bus.stall), 32'(!bad));

    @(negedge clk);
    if (bad) begin
      idle_inputs();
      exp_rd = 32'h0;
      #1;
      check_val("mis_pulse", 32'(bus.misaligned), 32'h1);
      check_val("mis_mem_req", 32'(bus.mem_req), 32'h0);
      check_val("mis_stall", 32'(bus.stall), 32'h0);
      check_val("mis_read_data", bus.read_data, 32'h0);
      @(negedge clk);
      #1;
      check_val("mis_pulse_end", 32'(bus.misaligned), 32'h0);
      check_val("mis_mem_req_after", 32'(bus.mem_req), 32'h0);
      $display("txn %0d: rd=%0d wr=%0d addr=%08h size=%0d -> misaligned", n_txn, rd, wr, a, sz);
      return;
    end

    for (int c = 1; c <= T; c++) begin
      cycles = c;
      check_val("wait_mem_req", 32'(bus.mem_req), 32'h1);
      check_val("wait_stall", 32'(bus.stall), 32'h1);
      check_val("wait_mem_addr", bus.mem_addr, e_addr);
      check_val("wait_mem_be", 32'(bus.mem_be), 32'(e_be));
      check_val("wait_mem_we", 32'(bus.mem_we), 32'(wr));
      check_val("wait_mem_wdata", bus.mem_wdata, e_wd);
      check_val("wait_read_data", bus.read_data, exp_rd);
      check_val("wait_misaligned", 32'(bus.misaligned), 32'h0);
      // Pipeline inputs wander while waiting; they must be ignored.
      bus.req_read  = 1'($urandom_range(0, 1));
      bus.req_write = 1'($urandom_range(0, 1));
      bus.addr      = $urandom;
      bus.wdata     = $urandom;
      bus.size      = 2'($urandom_range(0, 3));
      bus.sign_ext  = 1'($urandom_range(0, 1));
      if (c == ack_k) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdat;
        acked         = 1'b1;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      if (acked) break;
    end

    if (acked) begin
      if (!wr) exp_rd = model_load(sz, a, sx, rdat);
    end else begin
      exp_rd = 32'h0;
      exp_to = 1'b1;
    end

    idle_inputs();
    if (poke_done) begin
      bus.req_read  = 1'b1;
      bus.addr      = 32'h40;
      bus.size      = 2'd2;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
    end
    #1;
    check_val("done_stall", 32'(bus.stall), 32'h0);
    check_val("done_mem_req", 32'(bus.mem_req), 32'h0);
    check_val("done_read_data", bus.read_data, exp_rd);
    check_val("done_timeout_err", 32'(bus.timeout_err), 32'(exp_to));

    @(negedge clk);
    idle_inputs();
    #1;
    check_val("idle_stall", 32'(bus.stall), 32'h0);
    check_val("idle_mem_req", 32'(bus.mem_req), 32'h0);
    check_val("idle_read_data", bus.read_data, exp_rd);
    check_val("idle_timeout_err", 32'(bus.timeout_err), 32'(exp_to));
    $display("txn %0d: rd=%0d wr=%0d addr=%08h size=%0d ack=%0d wait=%0d -> read_data=%08h timeout=%0d",
             n_txn, rd, wr, a, sz, ack_k, cycles, bus.read_data, bus.timeout_err);
  endtask

  task automatic random_txns(input int count, input int max_ack);
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [1:0]  sz;
    int          kind;
    for (int i = 0; i < count; i++) begin
      kind = int'($urandom_range(0, 2));
      rd   = (kind != 1);
      wr   = (kind != 0);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
      end
      run_txn(rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)),
              int'($urandom_range(1, max_ack)), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    idle_inputs();
    rst    = 1'b1;
    exp_rd = 32'h0;
    exp_to = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
    check_val("lw_result", bus.read_data, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 2, 32'h8011_2233, 1'b0);
    check_val("lb_sext", bus.read_data, 32'hFFFF_FF80);
    run_txn(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 1, 32'h8011_2233, 1'b1);
    check_val("lb_zext", bus.read_data, 32'h0000_0080);
    run_txn(1'b1, 1'b1, 32'h202, 32'h0000_ABCD, 2'd1, 1'b0, 4, 32'h1234_5678, 1'b0);
    check_val("sh_keeps_read_data", bus.read_data, 32'h0000_0080);
    run_txn(1'b1, 1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 1, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h302, 32'h0, 2'd1, 1'b1, 2, 32'h9ABC_0000, 1'b0);
    check_val("lh_sext_upper", bus.read_data, 32'hFFFF_9ABC);

    random_txns(60, 6);

    run_txn(1'b1, 1'b0, 32'h400, 32'h0, 2'd2, 1'b0, T, 32'hCAFE_F00D, 1'b0);
    check_val("ack_in_last_cycle", bus.read_data, 32'hCAFE_F00D);
    run_txn(1'b1, 1'b0, 32'h404, 32'h0, 2'd2, 1'b0, 0, 32'h0, 1'b1);
    check_val("timeout_flag", 32'(bus.timeout_err), 32'h1);
    random_txns(10, 6);

    // Reset in the middle of WAIT, followed by the abandoned ack.
    @(negedge clk);
    bus.req_read = 1'b1;
    bus.addr     = 32'h500;
    bus.size     = 2'd2;
    @(negedge clk);
    idle_inputs();
    #1 check_val("pre_rst_mem_req", 32'(bus.mem_req), 32'h1);
    #1 rst = 1'b1;
    #1 check_all_zero("mid_wait_reset");
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    #1 check_all_zero("late_ack");
    exp_rd = 32'h0;
    exp_to = 1'b0;
    run_txn(1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b0, 2, 32'h0BAD_CAFE, 1'b0);
    check_val("after_reset_load", bus.read_data, 32'h0BAD_CAFE);

    random_txns(30, T + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in WAIT without mem_ack before abort.
REQ-002 clk  input  1  single pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_read  input  1  load request from the EX/MEM stage.
REQ-005 req_write  input  1  store request from the EX/MEM stage.
REQ-006 addr  input  32  byte address, the alu_result of the EX/MEM stage.
REQ-007 wdata  input  32  store data, right-aligned.
REQ-008 size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 sign_ext  input  1  loads: 1 sign-extends, 0 zero-extends.
REQ-010 read_data  output  32  load result toward the MEM/WB register.
REQ-011 stall  output  1  freezes the upstream pipeline while high.
REQ-012 mem_req  output  1  external memory request.
REQ-013 mem_we  output  1  external write enable.
REQ-014 mem_addr  output  32  word-aligned address: addr[31:2], 2'b00.
REQ-015 mem_be  output  4  byte enables, little-endian.
REQ-016 mem_wdata  output  32  store data replicated across lanes.
REQ-017 mem_ack  input  1  single-cycle completion from memory.
REQ-018 mem_rdata  input  32  read word, valid in the mem_ack cycle.
REQ-019 misaligned  output  1  one-cycle pulse on a rejected access.
REQ-020 timeout_err  output  1  sticky abort flag, cleared only by rst.

Function
REQ-021 The FSM SHALL use the states IDLE, WAIT and DONE.
REQ-022 In IDLE, a request is valid when req_read or req_write is high.
REQ-023 When req_read and req_write are both high, the request SHALL be treated as a store.
REQ-024 A request SHALL be misaligned when size=11, when a half access has addr[0]=1, or when a word access has addr[1:0]!=0.
REQ-025 A valid misaligned request SHALL cause no memory access; it pulses misaligned the next cycle, sets read_data=0, keeps stall low and stays in IDLE.
REQ-026 A valid aligned request SHALL set stall combinationally in the same cycle.
REQ-027 On that cycle's edge the block SHALL register mem_addr, mem_be, mem_we and mem_wdata, set mem_req=1 and enter WAIT.
REQ-028 In WAIT, mem_req and all mem_* outputs SHALL stay stable and stall SHALL stay high until mem_ack.
REQ-029 When mem_ack arrives in WAIT, the block SHALL drop mem_req next edge and enter DONE.
REQ-030 For a load, the same edge SHALL load read_data with the extracted and extended lane.
REQ-031 For a store, read_data SHALL be unchanged.
REQ-032 DONE SHALL last exactly one cycle with stall low; requests are ignored there, and the next state is IDLE.
REQ-033 Latency: with a request in cycle 0 and mem_ack in cycle k>=1, read_data is valid and stall is low in cycle k+1.
REQ-034 Byte lanes: a byte uses lane addr[1:0] and mem_be=1<<addr[1:0]; a half uses mem_be=0011 or 1100 by addr[1]; a word uses 1111.
REQ-035 mem_wdata SHALL be the byte replicated x4, the half replicated x2, or the full word.
REQ-036 A WAIT counter SHALL count from 0; on reaching TIMEOUT without mem_ack it SHALL drop mem_req, set timeout_err, set read_data=0 and enter DONE.
REQ-037 mem_ack in IDLE or DONE SHALL be ignored.
REQ-038 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as a normal completion.
REQ-039 Changes on req_*, addr, wdata or size during WAIT SHALL have no effect.

Reset
REQ-040 rst SHALL asynchronously force IDLE, counter=0, read_data=0, and 0 on stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, misaligned and timeout_err.
REQ-041 rst in WAIT SHALL abandon the access; a later mem_ack for it SHALL be ignored.

Verification
REQ-042 Load word: addr=0x100, mem_ack 3 cycles later with rdata=0xDEADBEEF -> stall high 4 cycles, then read_data=0xDEADBEEF.
REQ-043 Load byte: addr=0x103, sign_ext=1, rdata=0x80112233 -> read_data=0xFFFFFF80; with sign_ext=0 -> 0x00000080.
REQ-044 Store half: addr=0x202, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, read_data unchanged.
REQ-045 Word at addr=0x101 -> misaligned pulses, mem_req never rises, stall stays low.
REQ-046 No mem_ack for TIMEOUT=16 cycles -> timeout_err=1, read_data=0, back to IDLE; an ack in the abort cycle completes normally.
REQ-047 rst asserted mid-WAIT, then a late mem_ack -> all outputs 0, the FSM stays in IDLE.
